// File: rtl/mips_exec_mem_unit.sv
// Execute/memory slice of a single-cycle MIPS datapath: ALU control decode, 32-bit ALU, word data memory.
// Optional signed add/sub overflow flag is enabled by defining MIPS_ALU_OVERFLOW_EN.
module mips_exec_mem_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] store_data,
  input  logic        memread,
  input  logic        memwrite,
  output logic [3:0]  alu_ctrl,
  output logic        jump_reg,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] read_data
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] idx_s;
  logic              slt_s;

  // ALU control decode from aluop and funct
  always_comb begin
    alu_ctrl = OP_BAD;
    jump_reg = 1'b0;
    case (aluop)
      2'b00: alu_ctrl = OP_ADD;
      2'b01: alu_ctrl = OP_SUB;
      2'b11: alu_ctrl = OP_OR;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctrl = OP_ADD;
          6'b100010: alu_ctrl = OP_SUB;
          6'b100100: alu_ctrl = OP_AND;
          6'b100101: alu_ctrl = OP_OR;
          6'b101010: alu_ctrl = OP_SLT;
          6'b100111: alu_ctrl = OP_NOR;
          6'b000000: alu_ctrl = OP_SLL;
          6'b000010: alu_ctrl = OP_SRL;
          6'b001000: begin
            alu_ctrl = OP_ADD;
            jump_reg = 1'b1;
          end
          default:   alu_ctrl = OP_BAD;
        endcase
      end
      default: alu_ctrl = OP_BAD;
    endcase
  end

  assign slt_s = ($signed(operand_a) < $signed(operand_b));

  // 32-bit ALU datapath; unknown operations yield zero
  always_comb begin
    alu_result = 32'h0000_0000;
    case (alu_ctrl)
      OP_ADD:  alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_AND:  alu_result = operand_a & operand_b;
      OP_OR:   alu_result = operand_a | operand_b;
      OP_NOR:  alu_result = ~(operand_a | operand_b);
      OP_SLT:  alu_result = {31'd0, slt_s};
      OP_SLL:  alu_result = operand_b << shamt;
      OP_SRL:  alu_result = operand_b >> shamt;
      default: alu_result = 32'h0000_0000;
    endcase
  end

  assign zero = (alu_result == 32'h0000_0000);

`ifdef MIPS_ALU_OVERFLOW_EN
  // Signed overflow: result sign disagrees with what the operand signs force
  always_comb begin
    overflow = 1'b0;
    if (alu_ctrl == OP_ADD) begin
      overflow = (operand_a[31] == operand_b[31]) && (alu_result[31] != operand_a[31]);
    end else if (alu_ctrl == OP_SUB) begin
      overflow = (operand_a[31] != operand_b[31]) && (alu_result[31] != operand_a[31]);
    end else begin
      overflow = 1'b0;
    end
  end
`else
  assign overflow = 1'b0;
`endif

  // Byte address to word index; low two bits and high bits are dropped so accesses wrap
  assign idx_s = alu_result[ADDR_W+1:2];

  // Data memory write port; reset clears every word in one cycle and blocks the store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (memwrite) begin
      mem_r[idx_s] <= store_data;
    end
  end

  // Asynchronous read port, gated by memread and held at zero during reset
  always_comb begin
    read_data = 32'h0000_0000;
    if (reset) begin
      read_data = 32'h0000_0000;
    end else if (memread) begin
      read_data = mem_r[idx_s];
    end else begin
      read_data = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Self-checking bench for mips_exec_mem_unit: random stimulus against a behavioural model.
module tb_mips_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a, operand_b, store_data;
  logic        memread, memwrite;
  logic [3:0]  alu_ctrl;
  logic        jump_reg;
  logic [31:0] alu_result;
  logic        zero, overflow;
  logic [31:0] read_data;

  int passed = 0;
  int total  = 0;
  logic [31:0] mem_m [256];

`ifdef MIPS_ALU_OVERFLOW_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  mips_exec_mem_unit dut (
    .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .shamt(shamt),
    .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
    .memread(memread), .memwrite(memwrite), .alu_ctrl(alu_ctrl), .jump_reg(jump_reg),
    .alu_result(alu_result), .zero(zero), .overflow(overflow), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Reference: pick the named operation, then compute its result with plain arithmetic
  function automatic void ref_model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [3:0] ctrl, output logic jr,
                                    output logic [31:0] res, output logic ov);
    string name;
    longint s;
    jr = 1'b0;
    if (op == 2'b00) name = "add";
    else if (op == 2'b01) name = "sub";
    else if (op == 2'b11) name = "or";
    else begin
      name = "bad";
      if (fn == 6'h20) name = "add";
      if (fn == 6'h22) name = "sub";
      if (fn == 6'h24) name = "and";
      if (fn == 6'h25) name = "or";
      if (fn == 6'h2A) name = "slt";
      if (fn == 6'h27) name = "nor";
      if (fn == 6'h00) name = "sll";
      if (fn == 6'h02) name = "srl";
      if (fn == 6'h08) begin name = "add"; jr = 1'b1; end
    end
    ov = 1'b0;
    ctrl = 4'b1111;
    res = 32'h0;
    if (name == "add") begin
      ctrl = 4'b0010; res = a + b;
      s = longint'($signed(a)) + longint'($signed(b));
      ov = OV_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
    end
    if (name == "sub") begin
      ctrl = 4'b0110; res = a - b;
      s = longint'($signed(a)) - longint'($signed(b));
      ov = OV_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
    end
    if (name == "and") begin ctrl = 4'b0000; res = a & b; end
    if (name == "or")  begin ctrl = 4'b0001; res = a | b; end
    if (name == "nor") begin ctrl = 4'b1100; res = ~(a | b); end
    if (name == "slt") begin ctrl = 4'b0111; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
    if (name == "sll") begin ctrl = 4'b1000; res = b << sh; end
    if (name == "srl") begin ctrl = 4'b1001; res = b >> sh; end
  endfunction

  task automatic drive_alu(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b);
    aluop = op; funct = fn; shamt = sh; operand_a = a; operand_b = b;
    #1;
  endtask

  task automatic check_alu(input string tag);
    logic [3:0]  e_ctrl;
    logic        e_jr, e_ov;
    logic [31:0] e_res;
    ref_model(aluop, funct, shamt, operand_a, operand_b, e_ctrl, e_jr, e_res, e_ov);
    total++;
    if ({alu_ctrl, jump_reg, alu_result, zero, overflow} !== {e_ctrl, e_jr, e_res, (e_res == 32'h0), e_ov}) begin
      $display("FAIL %s aluop=%b funct=%b: got ctrl=%b jr=%b res=%h z=%b ov=%b, want ctrl=%b jr=%b res=%h z=%b ov=%b",
               tag, aluop, funct, alu_ctrl, jump_reg, alu_result, zero, overflow,
               e_ctrl, e_jr, e_res, (e_res == 32'h0), e_ov);
    end else passed++;
  endtask

  task automatic test_reset;
    memread = 1'b1; memwrite = 1'b1; store_data = 32'hFFFF_FFFF;
    drive_alu(2'b00, 6'h00, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (read_data !== 32'h0) $display("FAIL reset_read got=%h want=00000000", read_data);
    else passed++;
    @(negedge clk);
    memwrite = 1'b0; reset = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      operand_a = $urandom; #1;
      total++;
      if (read_data !== 32'h0) $display("FAIL reset_clear addr=%h got=%h want=00000000", operand_a, read_data);
      else passed++;
    end
    memread = 1'b0;
  endtask

  task automatic test_directed;
    drive_alu(2'b10, 6'b100010, 5'd0, 32'd5, 32'd7);
    total++;
    if ({alu_ctrl, alu_result, zero} !== {4'b0110, 32'hFFFF_FFFE, 1'b0})
      $display("FAIL dir_sub got ctrl=%b res=%h z=%b want 0110 fffffffe 0", alu_ctrl, alu_result, zero);
    else passed++;
    drive_alu(2'b10, 6'b101010, 5'd0, 32'd5, 32'd7);
    total++;
    if (alu_result !== 32'd1) $display("FAIL dir_slt got=%h want=00000001", alu_result); else passed++;
    drive_alu(2'b10, 6'b000000, 5'd4, 32'h0, 32'h0000_000F);
    total++;
    if (alu_result !== 32'h0000_00F0) $display("FAIL dir_sll got=%h want=000000f0", alu_result); else passed++;
    drive_alu(2'b10, 6'b000010, 5'd31, 32'h0, 32'h8000_0000);
    total++;
    if (alu_result !== 32'd1) $display("FAIL dir_srl got=%h want=00000001", alu_result); else passed++;
    drive_alu(2'b10, 6'b001000, 5'd0, 32'h40, 32'h0);
    total++;
    if ({jump_reg, alu_ctrl} !== {1'b1, 4'b0010}) $display("FAIL dir_jr got jr=%b ctrl=%b want 1 0010", jump_reg, alu_ctrl);
    else passed++;
    drive_alu(2'b01, 6'b001000, 5'd0, 32'd3, 32'd3);
    total++;
    if ({zero, jump_reg} !== {1'b1, 1'b0}) $display("FAIL dir_beq got z=%b jr=%b want 1 0", zero, jump_reg);
    else passed++;
    drive_alu(2'b10, 6'b111111, 5'd0, 32'd3, 32'd9);
    total++;
    if ({alu_ctrl, alu_result, zero} !== {4'b1111, 32'h0, 1'b1})
      $display("FAIL dir_bad got ctrl=%b res=%h z=%b want 1111 00000000 1", alu_ctrl, alu_result, zero);
    else passed++;
  endtask

  task automatic test_overflow;
    drive_alu(2'b00, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'd1);
    total++;
    if ({overflow, alu_result} !== {OV_EN, 32'h8000_0000})
      $display("FAIL ovf_add got ov=%b res=%h want ov=%b res=80000000", overflow, alu_result, OV_EN);
    else passed++;
    drive_alu(2'b00, 6'h00, 5'd0, 32'd1, 32'd1);
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_none got=%b want=0", overflow); else passed++;
    drive_alu(2'b01, 6'h00, 5'd0, 32'h8000_0000, 32'd1);
    check_alu("ovf_sub");
  endtask

  task automatic test_alu_random;
    logic [5:0] valid [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02, 6'h08};
    logic [31:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'h7FFF_FFFF ^ {31{a[0]}}};
      drive_alu(2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0) ? valid[$urandom_range(0, 8)] : 6'($urandom),
                5'($urandom), a, b);
      check_alu("alu_rand");
    end
  endtask

  task automatic test_memory;
    logic [31:0] addr, b, data;
    logic        we, re;
    int          idx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      addr = {22'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 2'($urandom)};
      b = (i % 3 == 0) ? $urandom : 32'h0;
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 3) != 0);
      data = $urandom;
      memwrite = we; memread = re; store_data = data;
      drive_alu(2'b00, 6'h00, 5'd0, addr - b, b);
      idx = int'((addr / 4) % 256);
      total++;
      if (read_data !== (re ? mem_m[idx] : 32'h0))
        $display("FAIL mem_pre addr=%h got=%h want=%h", addr, read_data, re ? mem_m[idx] : 32'h0);
      else passed++;
      @(posedge clk); #1;
      if (we) mem_m[idx] = data;
      total++;
      if (read_data !== (re ? mem_m[idx] : 32'h0))
        $display("FAIL mem_post addr=%h got=%h want=%h", addr, read_data, re ? mem_m[idx] : 32'h0);
      else passed++;
    end
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    memwrite = 1'b1; memread = 1'b0; store_data = 32'hDEAD_BEEF;
    drive_alu(2'b00, 6'h00, 5'd0, 32'h100, 32'd8);
    @(negedge clk);
    memwrite = 1'b0; memread = 1'b1; #1;
    total++;
    if (read_data !== 32'hDEAD_BEEF) $display("FAIL sw_lw got=%h want=deadbeef", read_data); else passed++;
    memread = 1'b0; #1;
    total++;
    if (read_data !== 32'h0) $display("FAIL lw_off got=%h want=00000000", read_data); else passed++;
    memwrite = 1'b1; store_data = 32'h1234_5678;
    drive_alu(2'b00, 6'h00, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    memwrite = 1'b0; memread = 1'b1; #1;
    total++;
    if (read_data !== 32'h1234_5678) $display("FAIL wr0 got=%h want=12345678", read_data); else passed++;
    memwrite = 1'b1; store_data = 32'hCAFE_F00D; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; memwrite = 1'b0; #1;
    total++;
    if (read_data !== 32'h0) $display("FAIL rst_wr0 got=%h want=00000000", read_data); else passed++;
    operand_a = 32'h108; #1;
    total++;
    if (read_data !== 32'h0) $display("FAIL rst_wr108 got=%h want=00000000", read_data); else passed++;
    memread = 1'b0;
  endtask

  initial begin
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; store_data = 32'h0;
    aluop = 2'b00; funct = 6'h00; shamt = 5'd0; operand_a = 32'h0; operand_b = 32'h0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_overflow;
    test_alu_random;
    test_memory;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
